// File: rtl/serial_subtractor_s.sv
// rtl/serial_subtractor_s.sv - bit-serial WIDTH-bit subtractor (a - b - borrow_in), LSB first
module serial_subtractor_s #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             input_borrow,
    output logic [WIDTH-1:0] diff,
    output logic             output_borrow,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_nx;

    // Operand shift registers drain LSB first; r_sh fills from the MSB side
    // so that after WIDTH shifts bit 0 of the result sits in r_sh[0].
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    // Sign bits captured at load: the shift registers no longer hold them
    // by the time the overflow flag is formed.
    logic             a_msb;
    logic             b_msb;

    logic             d_bit;
    logic             br_nx;
    logic [WIDTH-1:0] r_nx;
    logic             last_bit;

    // Single-bit full subtractor on the current LSBs and the borrow FF
    always_comb begin
        d_bit    = a_sh[0] ^ b_sh[0] ^ br;
        br_nx    = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        r_nx     = {d_bit, r_sh[WIDTH-1:1]};
        last_bit = (cnt == LAST);
    end

    // Next-state logic: IDLE -> RUN on start, RUN for WIDTH bits, DONE for one cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_bit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath: load operands in IDLE, shift one bit per cycle in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                a_sh  <= a;
                b_sh  <= b;
                br    <= input_borrow;
                cnt   <= '0;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
        end else if (state == RUN) begin
            a_sh <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            r_sh <= r_nx;
            br   <= br_nx;
            cnt  <= cnt + 1'b1;
        end
    end

    // Result registers update only once, on the edge that processes the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff          <= '0;
            output_borrow <= 1'b0;
            overflow      <= 1'b0;
        end else if ((state == RUN) && last_bit) begin
            diff          <= r_nx;
            output_borrow <= br_nx;
            overflow      <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor_s.sv
// tb/tb_serial_subtractor_s.sv - scoreboard bench for serial_subtractor_s
module tb_serial_subtractor_s;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         input_borrow;
    logic [W-1:0] diff;
    logic         output_borrow;
    logic         overflow;
    logic         busy;
    logic         done;

    serial_subtractor_s #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .a            (a),
        .b            (b),
        .input_borrow (input_borrow),
        .diff         (diff),
        .output_borrow(output_borrow),
        .overflow     (overflow),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for borrow, signed range for overflow
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mib, input int load_cyc);
        exp_t e;
        int   ua, ub, sa, sb, t, u;
        ua = int'(ma);
        ub = int'(mb);
        sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        u  = ua - ub - int'(mib);
        t  = sa - sb - int'(mib);
        e.d   = W'(u);
        e.bo  = (u < 0);
        e.ov  = (t < -(1 << (W - 1))) || (t > (1 << (W - 1)) - 1);
        e.cyc = load_cyc + W;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: done=1 with no operation outstanding (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("diff", int'(diff), int'(e.d));
                check("output_borrow", int'(output_borrow), int'(e.bo));
                check("overflow", int'(overflow), int'(e.ov));
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // One operation: load, then WIDTH+1 further edges while busy, ending in IDLE.
    // noise: 0 = quiet, 1 = random inputs/start while busy, 2 = start with a=1,b=2 during RUN
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tib,
                         input bit hold, input int noise);
        int load_cyc;
        a            = ta;
        b            = tb_v;
        input_borrow = tib;
        start        = 1'b1;
        @(posedge clk);
        #1;
        load_cyc = cyc;
        exp_q.push_back(model(ta, tb_v, tib, load_cyc));
        for (int i = 0; i <= W; i++) begin
            check("busy_active", int'(busy), 1);
            if (noise == 1) begin
                a            = W'($urandom);
                b            = W'($urandom);
                input_borrow = 1'($urandom);
                start        = 1'($urandom);
            end else if (noise == 2) begin
                a     = W'(1);
                b     = W'(2);
                start = 1'b1;
            end else begin
                start = hold;
            end
            @(posedge clk);
            #1;
        end
        start = hold;
        check("busy_idle", int'(busy), 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        a            = '0;
        b            = '0;
        input_borrow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_diff", int'(diff), 0);
        check("rst_borrow", int'(output_borrow), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(4'd9, 4'd3, 1'b0, 1'b0, 0);
        do_op(4'd3, 4'd9, 1'b0, 1'b0, 0);
        do_op(4'd8, 4'd1, 1'b0, 1'b0, 0);
        do_op(4'd0, 4'd0, 1'b1, 1'b0, 0);
        do_op(4'd5, 4'd5, 1'b0, 1'b0, 0);
        do_op(4'd9, 4'd3, 1'b0, 1'b0, 2);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_hold_diff", int'(diff), 6);

        // Asynchronous reset away from any clock edge clears a held result
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_diff", int'(diff), 0);
        check("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Start held high: back-to-back operations, one IDLE cycle between them
        do_op(4'd12, 4'd5, 1'b0, 1'b1, 0);
        do_op(4'd2, 4'd7, 1'b1, 1'b1, 0);
        do_op(4'd15, 4'd15, 1'b1, 1'b0, 0);

        // Reset in the middle of RUN abandons the operation with no done pulse
        a     = 4'd9;
        b     = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_diff", int'(diff), 0);
        check("midrun_rst_borrow", int'(output_borrow), 0);
        check("midrun_rst_busy", int'(busy), 0);
        check("midrun_rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(posedge clk);
        #1;
        check("after_rst_diff", int'(diff), 0);
        check("after_rst_busy", int'(busy), 0);
        do_op(4'd7, 4'd2, 1'b0, 1'b0, 0);

        // Randomized operations with interference while busy and random idle gaps
        for (int n = 0; n < 40; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, outstanding=%0d expected 0", exp_q.size());
        $fatal(1, "watchdog");
    end

endmodule
